// File: rtl/led_pkg.sv
// Shared APA102 framing constants, the serialiser state type and the RGB332 expansion.
// Latency: none (types, constants and a combinational function only).
// Backpressure: none.
package led_pkg;

  localparam int          APA102_START_BITS = 32;
  localparam int          APA102_END_BITS   = 32;
  localparam logic [2:0]  APA102_HDR        = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_LEDS,
    ST_END
  } shift_state_t;

  // RGB332 -> {B8, G8, R8}; the 2/3-bit fields are replicated to span full 8-bit range
  function automatic logic [23:0] rgb332_to_bgr24(input logic [7:0] p);
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    r8 = {p[7:5], p[7:5], p[7:6]};
    g8 = {p[4:2], p[4:2], p[4:3]};
    b8 = {p[1:0], p[1:0], p[1:0], p[1:0]};
    return {b8, g8, r8};
  endfunction

endpackage

// File: rtl/apa102_shifter.sv
// Serialises one LED column as an APA102 frame: start word, one word per LED, end word.
// Latency: first bit on mosi one cycle after start; 2*CLK_DIV cycles per bit.
// Backpressure: start is ignored while busy; the caller decides what to do with it.
module apa102_shifter
  import led_pkg::*;
#(
  parameter int NO_ARM_LED = 32,
  parameter int RGB_SIZE   = 8,
  parameter int CLK_DIV    = 4,
  parameter int BRIGHTNESS = 31
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NO_ARM_LED*RGB_SIZE-1:0] column,
  output logic                         busy,
  output logic                         sclk,
  output logic                         mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LED_W = (NO_ARM_LED > 1) ? $clog2(NO_ARM_LED) : 1;
  localparam logic [4:0] BR = 5'(BRIGHTNESS);

  shift_state_t                   state, state_nxt;
  logic [4:0]                     bit_cnt, bit_nxt;
  logic [LED_W-1:0]               led_cnt, led_nxt;
  logic [DIV_W-1:0]               div_cnt;
  logic [NO_ARM_LED*RGB_SIZE-1:0] column_r;
  logic                           mosi_nxt;
  logic                           tick;
  logic [31:0]                    led_word;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign busy = (state != ST_IDLE);

  // State, bit position, prescaler and registered SPI pins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      led_cnt  <= '0;
      div_cnt  <= '0;
      column_r <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
      led_cnt <= led_nxt;
      mosi    <= mosi_nxt;
      if (state == ST_IDLE && start)
        column_r <= column;
      if (state == ST_IDLE || tick)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DIV_W'(1);
      // sclk toggles every CLK_DIV cycles while framing; the last high half returns it low
      if (state == ST_IDLE)
        sclk <= 1'b0;
      else if (tick)
        sclk <= ~sclk;
    end
  end

  // Next bit position advances at the end of each high half; mosi is the bit at that position
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    led_nxt   = led_cnt;
    mosi_nxt  = 1'b0;
    led_word  = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_START;
          bit_nxt   = '0;
          led_nxt   = '0;
        end
      end
      default: begin
        if (tick && sclk) begin
          if (bit_cnt == 5'd31) begin
            bit_nxt = '0;
            case (state)
              ST_START: begin
                state_nxt = ST_LEDS;
                led_nxt   = '0;
              end
              ST_LEDS: begin
                if (led_cnt == LED_W'(NO_ARM_LED - 1))
                  state_nxt = ST_END;
                else
                  led_nxt = led_cnt + LED_W'(1);
              end
              default: state_nxt = ST_IDLE;
            endcase
          end else begin
            bit_nxt = bit_cnt + 5'd1;
          end
        end
      end
    endcase
    case (state_nxt)
      ST_LEDS: begin
        led_word = {APA102_HDR, BR,
                    rgb332_to_bgr24(column_r[int'(led_nxt)*RGB_SIZE +: 8])};
        mosi_nxt = led_word[5'd31 - bit_nxt];
      end
      ST_END:  mosi_nxt = 1'b1;
      default: mosi_nxt = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_arm_streamer.sv
// Tracks arm rotation from a hall index pulse and streams one LED column per angular slot.
// Latency: index edge acts 3 cycles after index_in rises; a slot's stream starts 1 cycle after its boundary.
// Backpressure: a slot boundary while the shifter is busy is dropped and sets sticky overrun.
module led_arm_streamer
  import led_pkg::*;
#(
  parameter int NO_ARM_LED         = 32,
  parameter int NO_DELTA_INTERVALS = 16,
  parameter int RGB_SIZE           = 8,
  parameter int OUT_DIM            = NO_DELTA_INTERVALS*NO_ARM_LED*RGB_SIZE,
  parameter int CLK_DIV            = 4,
  parameter int PERIOD_W           = 32,
  parameter int TIMEOUT_CYCLES     = 100000000,
  parameter int BRIGHTNESS         = 31
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [OUT_DIM-1:0]                    frame,
  input  logic                                  frame_valid,
  input  logic                                  index_in,
  output logic                                  spi_sclk,
  output logic                                  spi_mosi,
  output logic [$clog2(NO_DELTA_INTERVALS)-1:0] slot,
  output logic                                  locked,
  output logic                                  overrun
);

  localparam int SLOT_W = $clog2(NO_DELTA_INTERVALS);
  localparam int COL_W  = NO_ARM_LED*RGB_SIZE;

  logic [2:0]          sync;
  logic                index_edge;
  logic [PERIOD_W-1:0] cnt, period_reg, acc, acc_nxt;
  logic [PERIOD_W:0]   cnt_inc, acc_add;
  logic                armed, armed_nxt, locked_nxt;
  logic [SLOT_W-1:0]   slot_nxt;
  logic                start_req, start_q;
  logic [OUT_DIM-1:0]  shadow;
  logic                busy;

  assign index_edge = sync[1] & ~sync[2];
  assign cnt_inc    = {1'b0, cnt} + (PERIOD_W+1)'(1);
  assign acc_add    = {1'b0, acc} + (PERIOD_W+1)'(NO_DELTA_INTERVALS);

  // Lock and slot-advance decisions; an index edge overrides any slot advance
  always_comb begin
    armed_nxt  = armed;
    locked_nxt = locked;
    slot_nxt   = slot;
    acc_nxt    = acc;
    start_req  = 1'b0;
    if (index_edge) begin
      armed_nxt  = 1'b1;
      locked_nxt = armed && (cnt_inc < (PERIOD_W+1)'(TIMEOUT_CYCLES));
    end else if (cnt == PERIOD_W'(TIMEOUT_CYCLES)) begin
      armed_nxt  = 1'b0;
      locked_nxt = 1'b0;
    end
    if (index_edge) begin
      slot_nxt  = '0;
      acc_nxt   = '0;
      start_req = locked_nxt;
    end else if (locked) begin
      if (acc_add >= {1'b0, period_reg} && slot != SLOT_W'(NO_DELTA_INTERVALS - 1)) begin
        slot_nxt  = slot + SLOT_W'(1);
        acc_nxt   = PERIOD_W'(acc_add - {1'b0, period_reg});
        start_req = 1'b1;
      end else begin
        acc_nxt = PERIOD_W'(acc_add);
      end
    end
  end

  // Index synchroniser, revolution timing, lock, slot and shadow frame registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync       <= '0;
      cnt        <= '0;
      period_reg <= '0;
      armed      <= 1'b0;
      locked     <= 1'b0;
      acc        <= '0;
      slot       <= '0;
      start_q    <= 1'b0;
      shadow     <= '0;
      overrun    <= 1'b0;
    end else begin
      sync    <= {sync[1:0], index_in};
      armed   <= armed_nxt;
      locked  <= locked_nxt;
      acc     <= acc_nxt;
      slot    <= slot_nxt;
      start_q <= start_req;
      if (index_edge) begin
        period_reg <= cnt_inc[PERIOD_W-1:0];
        cnt        <= '0;
        if (frame_valid)
          shadow <= frame;
      end else if (cnt != PERIOD_W'(TIMEOUT_CYCLES)) begin
        cnt <= cnt + PERIOD_W'(1);
      end
      if (start_q && locked && busy)
        overrun <= 1'b1;
    end
  end

  apa102_shifter #(
    .NO_ARM_LED (NO_ARM_LED),
    .RGB_SIZE   (RGB_SIZE),
    .CLK_DIV    (CLK_DIV),
    .BRIGHTNESS (BRIGHTNESS)
  ) u_shifter (
    .clock  (clock),
    .reset  (reset),
    .start  (start_q & locked),
    .column (shadow[int'(slot)*COL_W +: COL_W]),
    .busy   (busy),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi)
  );

endmodule

// File: tb/tb_led_arm_streamer.sv
// Directed bench: lock, slot timing, stream content, overrun, timeout, shadow and async reset.
// Latency: checks sample #1 after the rising clock edge; the SPI monitor samples on the falling edge.
// Backpressure: not applicable.
module tb_led_arm_streamer;

  logic        clock;
  logic        reset;
  logic [63:0] frame;
  logic        frame_valid;
  logic        index_in;
  logic        spi_sclk;
  logic        spi_mosi;
  logic [1:0]  slot;
  logic        locked;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  led_arm_streamer #(
    .NO_ARM_LED         (2),
    .NO_DELTA_INTERVALS (4),
    .RGB_SIZE           (8),
    .OUT_DIM            (64),
    .CLK_DIV            (1),
    .PERIOD_W           (32),
    .TIMEOUT_CYCLES     (5000),
    .BRIGHTNESS         (31)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame       (frame),
    .frame_valid (frame_valid),
    .index_in    (index_in),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .slot        (slot),
    .locked      (locked),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SPI monitor: collect bits on sclk rises; two idle-low cycles close a stream
  logic [127:0] mon_sr;
  int           mon_bits = 0;
  int           mon_low = 0;
  logic         mon_prev = 1'b0;
  int           idle_mosi_bad = 0;
  logic [127:0] str_dat[$];
  int           str_len[$];

  always @(negedge clock) begin
    if (reset) begin
      mon_bits = 0;
      mon_low  = 0;
      mon_prev = 1'b0;
    end else begin
      if (spi_sclk && !mon_prev) begin
        mon_sr   = {mon_sr[126:0], spi_mosi};
        mon_bits = mon_bits + 1;
        mon_low  = 0;
      end else if (!spi_sclk) begin
        mon_low = mon_low + 1;
        if (mon_low == 2 && mon_bits != 0) begin
          str_dat.push_back(mon_sr);
          str_len.push_back(mon_bits);
          mon_bits = 0;
        end
        if (mon_low >= 2 && spi_mosi)
          idle_mosi_bad = idle_mosi_bad + 1;
      end
      mon_prev = spi_sclk;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Raise index for 3 cycles; returns just after the cycle in which the edge takes effect
  task automatic index_pulse();
    index_in = 1'b1;
    tick(3);
    index_in = 1'b0;
  endtask

  task automatic clear_streams();
    str_dat.delete();
    str_len.delete();
  endtask

  function automatic logic [127:0] get_str(input int i);
    return (i < str_dat.size()) ? str_dat[i] : 128'h0;
  endfunction

  function automatic int get_len(input int i);
    return (i < str_len.size()) ? str_len[i] : 0;
  endfunction

  // First frame, pixel index s*2+k
  function automatic logic [7:0] old_pix(input int i);
    case (i)
      0: return 8'h1C;
      1: return 8'hFF;
      2: return 8'hE0;
      3: return 8'h03;
      4: return 8'h00;
      5: return 8'h49;
      6: return 8'hA6;
      default: return 8'h00;
    endcase
  endfunction

  // Hand-expanded APA102 words for old_pix
  function automatic logic [31:0] old_word(input int i);
    case (i)
      0: return 32'hFF00FF00;
      1: return 32'hFFFFFFFF;
      2: return 32'hFF0000FF;
      3: return 32'hFFFF0000;
      4: return 32'hFF000000;
      5: return 32'hFF554949;
      6: return 32'hFFAA24B6;
      default: return 32'hFF000000;
    endcase
  endfunction

  function automatic logic [127:0] exp_stream(input logic [31:0] w0, input logic [31:0] w1);
    return {32'h0, w0, w1, 32'hFFFFFFFF};
  endfunction

  initial begin
    reset       = 1'b1;
    index_in    = 1'b0;
    frame       = '0;
    frame_valid = 1'b0;
    tick(3);
    check("rst_sclk",    128'(spi_sclk), 128'h0);
    check("rst_mosi",    128'(spi_mosi), 128'h0);
    check("rst_slot",    128'(slot),     128'h0);
    check("rst_locked",  128'(locked),   128'h0);
    check("rst_overrun", 128'(overrun),  128'h0);

    for (int i = 0; i < 8; i++) frame[i*8 +: 8] = old_pix(i);
    frame_valid = 1'b1;
    reset = 1'b0;
    tick(5);

    // First edge only arms
    index_pulse();
    tick(2);
    check("first_edge_unlocked", 128'(locked), 128'h0);
    tick(1995);
    index_pulse();
    check("second_edge_locked", 128'(locked), 128'h1);
    check("slot_after_edge",    128'(slot),   128'h0);
    check("no_stream_unlocked", 128'(str_dat.size()), 128'h0);
    tick(499);
    check("slot0_end",   128'(slot), 128'h0);
    tick(1);
    check("slot1_start", 128'(slot), 128'h1);
    tick(499);
    check("slot1_end",   128'(slot), 128'h1);
    tick(1);
    check("slot2_start", 128'(slot), 128'h2);
    tick(500);
    check("slot3_start", 128'(slot), 128'h3);
    tick(497);
    check("slot3_hold",  128'(slot), 128'h3);
    index_pulse();

    check("rev_stream_count", 128'(str_dat.size()), 128'h4);
    for (int s = 0; s < 4; s++)
      check($sformatf("rev_len_s%0d", s), 128'(get_len(s)), 128'd128);
    check("slot1_stream_hand", get_str(1),
          {32'h0, 32'hFF0000FF, 32'hFFFF0000, 32'hFFFFFFFF});
    for (int s = 0; s < 4; s++)
      check($sformatf("rev_dat_s%0d", s), get_str(s),
            exp_stream(old_word(s*2), old_word(s*2+1)));
    clear_streams();

    // Frame change mid-revolution must not reach the strip until the next edge
    tick(700);
    for (int i = 0; i < 8; i++) frame[i*8 +: 8] = 8'hE0;
    tick(1297);
    index_pulse();
    check("shadow_count", 128'(str_dat.size()), 128'h4);
    check("shadow_old_s2", get_str(2), exp_stream(old_word(4), old_word(5)));
    check("shadow_old_s3", get_str(3), exp_stream(old_word(6), old_word(7)));
    clear_streams();
    tick(300);
    check("new_frame_s0", get_str(0), exp_stream(32'hFF0000FF, 32'hFF0000FF));
    check("no_overrun_yet", 128'(overrun), 128'h0);

    // 400-cycle revolutions: slots every 100 cycles, shorter than one stream
    tick(97);
    index_pulse();
    clear_streams();
    tick(397);
    index_pulse();
    tick(397);
    index_pulse();
    check("overrun_set", 128'(overrun), 128'h1);
    tick(600);
    check("overrun_stream_count", 128'(str_dat.size()), 128'h4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("overrun_len_%0d", i), 128'(get_len(i)), 128'd128);
      check($sformatf("overrun_dat_%0d", i), get_str(i),
            exp_stream(32'hFF0000FF, 32'hFF0000FF));
    end

    // No more edges: lock drops once cnt reaches 5000
    tick(4400);
    check("lock_before_timeout", 128'(locked), 128'h1);
    tick(1);
    check("lock_after_timeout", 128'(locked), 128'h0);
    clear_streams();
    tick(600);
    check("quiet_streams", 128'(str_dat.size()), 128'h0);
    check("quiet_sclk", 128'(spi_sclk), 128'h0);
    check("quiet_mosi", 128'(spi_mosi), 128'h0);
    check("overrun_sticky", 128'(overrun), 128'h1);

    // Re-lock after timeout needs two edges again
    index_pulse();
    check("relock_first_edge", 128'(locked), 128'h0);
    tick(1997);
    index_pulse();
    check("relock_second_edge", 128'(locked), 128'h1);
    tick(600);
    check("pre_reset_slot", 128'(slot), 128'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_sclk",    128'(spi_sclk), 128'h0);
    check("async_rst_mosi",    128'(spi_mosi), 128'h0);
    check("async_rst_slot",    128'(slot),     128'h0);
    check("async_rst_locked",  128'(locked),   128'h0);
    check("async_rst_overrun", 128'(overrun),  128'h0);
    tick(3);
    reset = 1'b0;
    tick(5);
    check("idle_mosi_low", 128'(idle_mosi_bad), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
